regfile_panel_ctrl: RTL
=======================

// Module: regfile_panel_ctrl
// PURPOSE
//  Fully synchronous front-panel controller for the register-file board harness.
//  Debounces the push-buttons and loads configuration and data words from the switches in three steps.
//  Issues single-cycle write and clear strobes to the register file.
//  Cycles a registered display word over N_RD read ports, then PC, then a blank entry, for the 7-segment Display.
//  No button is ever used as a clock.
// PARAMETERS
//  DATA_W      32         register width; switch and LED width equal DATA_W
//  ADDR_W      4          register-address field width
//  MODE_W      5          processor-mode field width
//  N_RD        3          number of read ports (1..6)
//  DEB_CYCLES  1000000    stable clocks needed to accept a button level change (10 ms at 100 MHz)
// PORTS
//  clk         in   1              system clock
//  Rst_n       in   1              asynchronous active-low reset
//  sw          in   DATA_W         switch word
//  btn_arm     in   1              level; loading is enabled only while the debounced level is 1
//  btn_load    in   1              load button
//  btn_commit  in   1              register-file write button
//  btn_clr     in   1              register-file clear button
//  btn_show    in   1              display-advance button
//  r_data      in   N_RD*DATA_W    read-port data; port i is at [i*DATA_W +: DATA_W]
//  pc_data     in   DATA_W         current PC
//  r_addr      out  N_RD*ADDR_W    read addresses; port i is at [i*ADDR_W +: ADDR_W]
//  mode        out  MODE_W         processor mode
//  w_addr      out  ADDR_W         write address
//  write_reg   out  1              write-register enable
//  write_pc    out  1              write-PC enable
//  w_data      out  DATA_W         write data
//  pc_new      out  DATA_W         new PC value
//  rf_wr       out  1              one-cycle write strobe
//  rf_clr      out  1              one-cycle clear strobe
//  disp_data   out  DATA_W+1       {value, valid} to Display
//  led         out  DATA_W         status LEDs
// BEHAVIOUR
//  Reset values (Rst_n=0):
//  - All outputs are 0, step=CFG, show_idx=0.
//  - disp_data = {32'h88888888 (replicated to DATA_W), 1'b0}.
//  Button path:
//  - 2-FF synchroniser, then a debounce counter.
//  - The debounced level changes only after DEB_CYCLES consecutive equal samples.
//  - A press is a one-clk pulse on each debounced 0->1 transition.
//  - Press latency is 2+DEB_CYCLES+1 clk after the raw input settles.
//  Load FSM (step: CFG -> WDATA -> PCNEW -> CFG). On a load press with arm=1:
//  - CFG: r_addr[i] <= sw[DATA_W-1-i*ADDR_W -: ADDR_W]; mode <= sw[11 +: MODE_W];
//    w_addr <= sw[4 +: ADDR_W]; write_reg <= sw[1]; write_pc <= sw[0].
//  - WDATA: w_data <= sw.
//  - PCNEW: pc_new <= sw.
//  - A load press with arm=0 is ignored and step holds.
//  Strobes:
//  - A commit press gives rf_wr=1 for exactly one clk on the following cycle.
//  - A clr press does the same on rf_clr.
//  - Loaded values update on the clock edge after the load press. A commit press in the same cycle
//    drives rf_wr the cycle after that edge, so the write sees the newly loaded values.
//  - A clr press also returns step to CFG. Loaded values are kept.
//  - Clear has priority: commit and load presses in the same cycle as clr are dropped.
//  Display, on a show press:
//  - show_idx 0..N_RD-1: disp_data <= {r_data[idx], 1}.
//  - show_idx N_RD: disp_data <= {pc_data, 1}.
//  - show_idx N_RD+1: disp_data <= {0x8.., 0}.
//  - show_idx then advances modulo N_RD+2.
//  - The display word is a snapshot; it is not refreshed until the next show press.
//  LEDs: led[1:0]=step; led[2]=arm; led[13]=write_pc; led[14]=write_reg; led[19:15]=mode;
//        led[31:29]=show_idx; all other LEDs are 0.
//  Width rule: sw/LED field positions above are for DATA_W=32. Elaboration fails if N_RD*ADDR_W > DATA_W-16.
//  Reset mid-debounce: counters clear and no press is emitted.
// STRUCTURE
//  - Package regfile_panel_pkg:
//    - step enum {CFG=0, WDATA=1, PCNEW=2}
//    - CFG field LSB constants (MODE_LSB=11, WADDR_LSB=4, WREG_BIT=1, WPC_BIT=0)
//    - blank display constant
//  - Sub-module btn_debounce (sync + counter + rise pulse), parameter DEB_CYCLES.
//    Instantiated 5 times (arm, load, commit, clr, show).
// TESTING (DEB_CYCLES=4, defaults otherwise)
//  1. Release reset with no presses -> all outputs 0, disp_data={0x88888888,0}; a 3-clk glitch on btn_load
//     gives no press.
//  2. arm=1, sw=0x1230_0852, load -> r_addr A/B/C = 1/2/3, mode=0x01, w_addr=5, write_reg=1,
//     write_pc=0, led[1:0]=1.
//  3. sw=0xDEADBEEF then load, sw=0x00000040 then load -> w_data=0xDEADBEEF, pc_new=0x40, step=CFG.
//     Commit -> rf_wr high for exactly 1 clk.
//  4. arm=0, load -> step unchanged. Clr and commit in the same cycle -> rf_clr pulse, no rf_wr, step=CFG.
//  5. r_data={3,2,1}, pc_data=0x44, six show presses -> disp_data values 1,2,3,0x44, then blank with
//     valid=0, then 1.
//  6. Assert Rst_n mid-WDATA with btn_show held -> async clear of all outputs; no show press after release
//     until the button is released and pressed again.

Source files
------------

// File: rtl/regfile_panel_pkg.sv
// Shared types and constants for the register-file front-panel controller.
package regfile_panel_pkg;

   typedef enum logic [1:0] {
      CFG   = 2'd0,
      WDATA = 2'd1,
      PCNEW = 2'd2
   } step_t;

   localparam int MODE_LSB  = 11;
   localparam int WADDR_LSB = 4;
   localparam int WREG_BIT  = 1;
   localparam int WPC_BIT   = 0;
   localparam int SHOW_W    = 3;
   localparam logic [31:0] BLANK_WORD = 32'h8888_8888;

   // Successor of a step in the three-stage load sequence.
   function automatic step_t step_advance(input step_t s);
      step_t n;
      case (s)
         CFG:     n = WDATA;
         WDATA:   n = PCNEW;
         PCNEW:   n = CFG;
         default: n = CFG;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and rising-edge press pulse.
module btn_debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

   logic             sync1_r, sync2_r, prev_r;
   logic             level_r, level_q_r, ready_r, press_r;
   logic [CNT_W-1:0] cnt_r, cnt_next_s;
   logic             accept_s;

   // Count consecutive equal synchronised samples, saturating at CNT_MAX.
   always_comb begin
      cnt_next_s = cnt_r;
      if (sync2_r != prev_r) begin
         cnt_next_s = CNT_W'(1);
      end else if (cnt_r != CNT_MAX) begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_next_s = CNT_MAX;
      end
      accept_s = (cnt_next_s == CNT_MAX);
   end

   // A rise only counts once a released level has been accepted since reset,
   // so a button held through reset never produces a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r   <= 1'b0;
         sync2_r   <= 1'b0;
         prev_r    <= 1'b0;
         cnt_r     <= {CNT_W{1'b0}};
         level_r   <= 1'b0;
         level_q_r <= 1'b0;
         ready_r   <= 1'b0;
         press_r   <= 1'b0;
      end else begin
         sync1_r   <= btn;
         sync2_r   <= sync1_r;
         prev_r    <= sync2_r;
         cnt_r     <= cnt_next_s;
         level_r   <= accept_s ? sync2_r : level_r;
         ready_r   <= ready_r | (accept_s & ~sync2_r);
         level_q_r <= level_r;
         press_r   <= level_r & ~level_q_r & ready_r;
      end
   end

   assign level = level_r;
   assign press = press_r;

endmodule

// File: rtl/regfile_panel_ctrl.sv
// Front-panel controller: debounced buttons load config/data words from the switches,
// strobe register-file write/clear, and step a snapshot display over read ports and PC.
module regfile_panel_ctrl
   import regfile_panel_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 4,
   parameter int MODE_W     = 5,
   parameter int N_RD       = 3,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     Rst_n,
   input  logic [DATA_W-1:0]        sw,
   input  logic                     btn_arm,
   input  logic                     btn_load,
   input  logic                     btn_commit,
   input  logic                     btn_clr,
   input  logic                     btn_show,
   input  logic [N_RD*DATA_W-1:0]   r_data,
   input  logic [DATA_W-1:0]        pc_data,
   output logic [N_RD*ADDR_W-1:0]   r_addr,
   output logic [MODE_W-1:0]        mode,
   output logic [ADDR_W-1:0]        w_addr,
   output logic                     write_reg,
   output logic                     write_pc,
   output logic [DATA_W-1:0]        w_data,
   output logic [DATA_W-1:0]        pc_new,
   output logic                     rf_wr,
   output logic                     rf_clr,
   output logic [DATA_W:0]          disp_data,
   output logic [DATA_W-1:0]        led
);

   if ((N_RD < 1) || (N_RD > 6) || (DATA_W < 32) || (MODE_W > 14) ||
       (N_RD * ADDR_W > DATA_W - 16)) begin : g_bad_params
      $error("regfile_panel_ctrl: unsupported parameter combination");
   end

   logic arm_lvl_s, load_press_s, commit_press_s, clr_press_s, show_press_s;
   logic arm_press_s, load_lvl_s, commit_lvl_s, clr_lvl_s, show_lvl_s;
   logic unused_lvl_s;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arm (
      .clk(clk), .rst_n(Rst_n), .btn(btn_arm), .level(arm_lvl_s), .press(arm_press_s));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load (
      .clk(clk), .rst_n(Rst_n), .btn(btn_load), .level(load_lvl_s), .press(load_press_s));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_commit (
      .clk(clk), .rst_n(Rst_n), .btn(btn_commit), .level(commit_lvl_s), .press(commit_press_s));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
      .clk(clk), .rst_n(Rst_n), .btn(btn_clr), .level(clr_lvl_s), .press(clr_press_s));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_show (
      .clk(clk), .rst_n(Rst_n), .btn(btn_show), .level(show_lvl_s), .press(show_press_s));

   assign unused_lvl_s = &{1'b0, arm_press_s, load_lvl_s, commit_lvl_s, clr_lvl_s, show_lvl_s};

   step_t                   step_r, step_next_s;
   logic [N_RD*ADDR_W-1:0]  r_addr_r, cfg_raddr_s;
   logic [MODE_W-1:0]       mode_r;
   logic [ADDR_W-1:0]       w_addr_r;
   logic                    write_reg_r, write_pc_r;
   logic [DATA_W-1:0]       w_data_r, pc_new_r;
   logic                    rf_wr_r, rf_clr_r;
   logic [DATA_W:0]         disp_r, disp_next_s;
   logic [SHOW_W-1:0]       show_idx_r, show_idx_next_s;
   logic [DATA_W-1:0]       blank_s, rd_sel_s, led_s;
   logic                    load_ok_s, commit_ok_s;

   // Clear wins over load and commit presses in the same cycle.
   assign load_ok_s   = load_press_s & arm_lvl_s & ~clr_press_s;
   assign commit_ok_s = commit_press_s & ~clr_press_s;

   for (genvar b = 0; b < DATA_W; b++) begin : g_blank
      assign blank_s[b] = BLANK_WORD[b % 32];
   end

   // Read-address fields are packed from the top of the switch word downwards.
   always_comb begin
      cfg_raddr_s = {(N_RD*ADDR_W){1'b0}};
      for (int i = 0; i < N_RD; i++) begin
         cfg_raddr_s[i*ADDR_W +: ADDR_W] = sw[DATA_W-1-i*ADDR_W -: ADDR_W];
      end
   end

   // Display source selection and show-index wrap.
   always_comb begin
      rd_sel_s = {DATA_W{1'b0}};
      for (int i = 0; i < N_RD; i++) begin
         rd_sel_s = (show_idx_r == SHOW_W'(i)) ? r_data[i*DATA_W +: DATA_W] : rd_sel_s;
      end
      if (show_idx_r < SHOW_W'(N_RD)) begin
         disp_next_s = {rd_sel_s, 1'b1};
      end else if (show_idx_r == SHOW_W'(N_RD)) begin
         disp_next_s = {pc_data, 1'b1};
      end else begin
         disp_next_s = {blank_s, 1'b0};
      end
      show_idx_next_s = (show_idx_r == SHOW_W'(N_RD + 1)) ? {SHOW_W{1'b0}}
                                                          : show_idx_r + SHOW_W'(1);
   end

   // Load-step next state.
   always_comb begin
      step_next_s = step_r;
      if (clr_press_s) begin
         step_next_s = CFG;
      end else if (load_ok_s) begin
         step_next_s = step_advance(step_r);
      end else begin
         step_next_s = step_r;
      end
   end

   // Load-step state register.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         step_r <= CFG;
      end else begin
         step_r <= step_next_s;
      end
   end

   // Loaded fields, strobes and display snapshot.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_addr_r    <= {(N_RD*ADDR_W){1'b0}};
         mode_r      <= {MODE_W{1'b0}};
         w_addr_r    <= {ADDR_W{1'b0}};
         write_reg_r <= 1'b0;
         write_pc_r  <= 1'b0;
         w_data_r    <= {DATA_W{1'b0}};
         pc_new_r    <= {DATA_W{1'b0}};
         rf_wr_r     <= 1'b0;
         rf_clr_r    <= 1'b0;
         disp_r      <= {blank_s, 1'b0};
         show_idx_r  <= {SHOW_W{1'b0}};
      end else begin
         rf_wr_r  <= commit_ok_s;
         rf_clr_r <= clr_press_s;
         if (load_ok_s) begin
            case (step_r)
               CFG: begin
                  r_addr_r    <= cfg_raddr_s;
                  mode_r      <= sw[MODE_LSB +: MODE_W];
                  w_addr_r    <= sw[WADDR_LSB +: ADDR_W];
                  write_reg_r <= sw[WREG_BIT];
                  write_pc_r  <= sw[WPC_BIT];
               end
               WDATA:   w_data_r <= sw;
               PCNEW:   pc_new_r <= sw;
               default: w_data_r <= w_data_r;
            endcase
         end
         if (show_press_s) begin
            disp_r     <= disp_next_s;
            show_idx_r <= show_idx_next_s;
         end
      end
   end

   // Status LEDs are straight taps of registered state.
   always_comb begin
      led_s              = {DATA_W{1'b0}};
      led_s[1:0]         = step_r;
      led_s[2]           = arm_lvl_s;
      led_s[13]          = write_pc_r;
      led_s[14]          = write_reg_r;
      led_s[15 +: MODE_W] = mode_r;
      led_s[31:29]       = show_idx_r;
   end

   assign r_addr    = r_addr_r;
   assign mode      = mode_r;
   assign w_addr    = w_addr_r;
   assign write_reg = write_reg_r;
   assign write_pc  = write_pc_r;
   assign w_data    = w_data_r;
   assign pc_new    = pc_new_r;
   assign rf_wr     = rf_wr_r;
   assign rf_clr    = rf_clr_r;
   assign disp_data = disp_r;
   assign led       = led_s;

endmodule
